// File: rtl/ahbl_apb_bridge_mslot_if.sv
// ---------------------------------------------------------------------------
// ahbl_apb_bridge_mslot_if
// Bus bundle between an AHB-Lite master side and the APB slot group, as seen
// by the multi-slot AHB-Lite to APB4 bridge.
//
//   AHB-Lite : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADYIN
//              (into the bridge); HREADYOUT, HRDATA, HRESP (out of it).
//   APB4     : PADDR, PSEL (one-hot per slot), PENABLE, PWRITE, PWDATA,
//              PSTRB, PPROT (out of the bridge); PRDATA (slot k at
//              [32k+31:32k]), PREADY, PSLVERR (per slot, into the bridge).
//
// Modports:
//   slave  - the bridge (AHB slave, APB master).
//   master - the surrounding system (AHB master plus the APB peripherals).
// ---------------------------------------------------------------------------
interface ahbl_apb_bridge_mslot_if #(
  parameter int NUM_SLOTS      = 16,
  parameter int APB_ADDR_WIDTH = 32
);
  // AHB-Lite
  logic                        HSEL;
  logic [31:0]                 HADDR;
  logic [1:0]                  HTRANS;
  logic                        HWRITE;
  logic [2:0]                  HSIZE;
  logic [3:0]                  HPROT;
  logic [31:0]                 HWDATA;
  logic                        HREADYIN;
  logic                        HREADYOUT;
  logic [31:0]                 HRDATA;
  logic                        HRESP;
  // APB4
  logic [APB_ADDR_WIDTH-1:0]   PADDR;
  logic [NUM_SLOTS-1:0]        PSEL;
  logic                        PENABLE;
  logic                        PWRITE;
  logic [31:0]                 PWDATA;
  logic [3:0]                  PSTRB;
  logic [2:0]                  PPROT;
  logic [NUM_SLOTS*32-1:0]     PRDATA;
  logic [NUM_SLOTS-1:0]        PREADY;
  logic [NUM_SLOTS-1:0]        PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADYIN,
    output HREADYOUT, HRDATA, HRESP,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADYIN,
    input  HREADYOUT, HRDATA, HRESP,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahbl_apb_bridge_mslot.sv
// ---------------------------------------------------------------------------
// ahbl_apb_bridge_mslot
// AHB-Lite slave to APB4 master bridge serving up to 16 APB slots. The slot
// is decoded from HADDR[SLOT_LSB+3:SLOT_LSB]; per-slot PRDATA/PREADY/PSLVERR
// are muxed internally. Adds PSTRB/PPROT generation, PREADY wait states with
// an optional timeout, and the two-cycle AHB ERROR response. All outputs are
// registered.
//
// Ports:
//   HCLK   - sole clock.
//   HRESET - synchronous, active-high reset.
//   bus    - ahbl_apb_bridge_mslot_if.slave (AHB-Lite slave + APB4 master).
//
// Parameters:
//   NUM_SLOTS      - number of APB slots (1..16).
//   SLOT_LSB       - HADDR bit where the 4-bit slot index starts.
//   APB_ADDR_WIDTH - PADDR width; PADDR = HADDR[APB_ADDR_WIDTH-1:0].
//   MAX_WAIT       - PREADY-low ACCESS cycles before abort; 0 = no timeout.
// ---------------------------------------------------------------------------
module ahbl_apb_bridge_mslot #(
  parameter int NUM_SLOTS      = 16,
  parameter int SLOT_LSB       = 12,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int MAX_WAIT       = 255
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  ahbl_apb_bridge_mslot_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t      state;
  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [1:0]  hprot_q;   // only the privilege and data/opcode bits feed PPROT
  logic [3:0]  slot_q;
  logic [15:0] wait_cnt;

  // HTRANS[0] only separates NONSEQ from SEQ (both treated alike) and
  // HPROT[3:2] have no APB4 equivalent.
  logic unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HPROT[3:2]};

  logic                 accept;
  logic [31:0]          sel_rdata;
  logic                 sel_ready;
  logic                 sel_err;
  logic [NUM_SLOTS-1:0] slot_onehot;
  logic                 bad_access;
  logic [3:0]           strb;
  logic [15:0]          wait_next;
  logic                 timeout;

  assign accept     = bus.HSEL && bus.HREADYIN && bus.HTRANS[1];
  assign bad_access = ({28'd0, slot_q} >= 32'(NUM_SLOTS)) || (hsize_q > 3'd2);
  assign wait_next  = wait_cnt + 16'd1;
  assign timeout    = (MAX_WAIT != 0) && (wait_next == 16'(MAX_WAIT));

  // Slot mux and one-hot select. Other slots' inputs never reach the FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel_rdata   = '0;
    sel_ready   = 1'b0;
    sel_err     = 1'b0;
    slot_onehot = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q == 4'(k)) begin
        sel_rdata      = bus.PRDATA[k*32 +: 32];
        sel_ready      = bus.PREADY[k];
        sel_err        = bus.PSLVERR[k];
        slot_onehot[k] = 1'b1;
      end
    end
  end

  // Byte lanes for writes; reads drive no strobes.
  always_comb begin
    strb = 4'b0000;
    if (hwrite_q) begin
      case (hsize_q)
        3'd0:    strb = 4'b0001 << haddr_q[1:0];
        3'd1:    strb = haddr_q[1] ? 4'b1100 : 4'b0011;
        3'd2:    strb = 4'b1111;
        default: strb = 4'b0000;
      endcase
    end
  end

  // NOTE: the reset branch is synchronous and covers every register,
  // including the latched address-phase copies, so no X survives reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= S_IDLE;
      haddr_q       <= '0;
      hwrite_q      <= 1'b0;
      hsize_q       <= '0;
      hprot_q       <= '0;
      slot_q        <= '0;
      wait_cnt      <= '0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 1'b0;
      bus.HRDATA    <= '0;
      bus.PSEL      <= '0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.PSTRB     <= '0;
      bus.PPROT     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          // IDLE/BUSY with HSEL fall through here: zero-wait OKAY.
          if (accept) begin
            haddr_q       <= bus.HADDR;
            hwrite_q      <= bus.HWRITE;
            hsize_q       <= bus.HSIZE;
            hprot_q       <= bus.HPROT[1:0];
            slot_q        <= bus.HADDR[SLOT_LSB +: 4];
            bus.HREADYOUT <= 1'b0;
            state         <= S_LATCH;
          end
        end

        S_LATCH: begin
          // HWDATA belongs to the data phase, i.e. this cycle.
          bus.PWDATA <= bus.HWDATA;
          if (bad_access) begin
            bus.HRESP <= 1'b1;
            state     <= S_ERR1;
          end else begin
            bus.PSEL    <= slot_onehot;
            bus.PENABLE <= 1'b0;
            bus.PADDR   <= haddr_q[APB_ADDR_WIDTH-1:0];
            bus.PWRITE  <= hwrite_q;
            bus.PSTRB   <= strb;
            bus.PPROT   <= {~hprot_q[0], 1'b1, hprot_q[1]};
            wait_cnt    <= '0;
            state       <= S_SETUP;
          end
        end

        S_SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= S_ACCESS;
        end

        S_ACCESS: begin
          if (sel_ready) begin
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            if (sel_err) begin
              bus.HRESP <= 1'b1;
              state     <= S_ERR1;
            end else begin
              if (!hwrite_q) bus.HRDATA <= sel_rdata;
              bus.HREADYOUT <= 1'b1;
              state         <= S_IDLE;
            end
          end else begin
            wait_cnt <= wait_next;
            if (timeout) begin
              bus.PSEL    <= '0;
              bus.PENABLE <= 1'b0;
              bus.HRESP   <= 1'b1;
              state       <= S_ERR1;
            end
          end
        end

        // First ERROR cycle holds HREADYOUT low so the master can cancel.
        S_ERR1: begin
          bus.HRESP     <= 1'b1;
          bus.HREADYOUT <= 1'b1;
          state         <= S_ERR2;
        end

        S_ERR2: begin
          bus.HRESP <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
